roce_tx_work_scheduler: RTL and testbench
=========================================

ROCE_TX_WORK_SCHEDULER -- requirements
Module: roce_tx_work_scheduler

Interface
REQ-001 SHALL have parameter PMTU_LOG2, default 12, meaning log2 of path MTU in bytes (legal values 8..12).
REQ-002 SHALL have port clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port s_wr_valid  input  1  work request valid.
REQ-004 SHALL have port s_wr_ready  output  1  work request accepted.
REQ-005 SHALL have port s_wr_length  input  32  DMA length in bytes.
REQ-006 SHALL have port s_wr_rem_addr  input  64  remote virtual address.
REQ-007 SHALL have port s_wr_r_key  input  32  remote key.
REQ-008 SHALL have port s_wr_rem_qpn  input  24  destination QPN.
REQ-009 SHALL have port s_wr_psn  input  24  starting PSN.
REQ-010 SHALL have port m_pkt_valid  output  1  packet descriptor valid.
REQ-011 SHALL have port m_pkt_ready  input  1  packet generator ready.
REQ-012 SHALL have ports m_pkt_opcode  output  8; m_pkt_psn  output  24; m_pkt_addr  output  64; m_pkt_len  output  13; m_pkt_reth  output  1; m_pkt_r_key  output  32; m_pkt_qpn  output  24; m_pkt_dma_len  output  32.
REQ-013 SHALL have ports next_psn  output  24  PSN following last issued packet; done  output  1  one-cycle completion pulse; busy  output  1  transfer in progress.

Function
REQ-014 SHALL implement states IDLE and ISSUE; IDLE->ISSUE on s_wr_valid&&s_wr_ready; ISSUE->IDLE on handshake of final packet.
REQ-015 SHALL drive s_wr_ready=1 only in IDLE and not in reset.
REQ-016 SHALL register all request fields on acceptance; first m_pkt_valid SHALL assert the cycle after acceptance.
REQ-017 SHALL compute packet count = ceil(length/2^PMTU_LOG2), minimum 1; length 0 SHALL produce one ONLY packet with m_pkt_len=0.
REQ-018 SHALL emit opcodes: single packet 0x0A (WRITE_ONLY); else 0x06 (FIRST), 0x07 (MIDDLE) for interior, 0x08 (LAST).
REQ-019 SHALL set m_pkt_len=2^PMTU_LOG2 for all but the final packet; final = length - (count-1)*2^PMTU_LOG2.
REQ-020 SHALL assert m_pkt_reth only on FIRST/ONLY, carrying m_pkt_addr=s_wr_rem_addr, m_pkt_r_key, m_pkt_dma_len=length.
REQ-021 SHALL advance m_pkt_addr by 2^PMTU_LOG2 per packet (64-bit wrap) and m_pkt_psn by 1 modulo 2^24.
REQ-022 SHALL hold all m_pkt_* stable while m_pkt_valid&&!m_pkt_ready; SHALL sustain one packet per cycle with m_pkt_ready=1.
REQ-023 SHALL update next_psn = final PSN+1 (mod 2^24) on final handshake and pulse done the following cycle.
REQ-024 SHALL drive busy=1 from acceptance cycle+1 through the final handshake cycle inclusive.
REQ-025 SHALL ignore s_wr_valid while in ISSUE (no queuing).
REQ-026 SHALL compute remaining length with a 32-bit down-counter; no 33-bit overflow for length up to 2^32-1.

Reset
REQ-027 SHALL on rst return to IDLE, clear m_pkt_valid, done, busy, next_psn to 0, s_wr_ready to 0; other datapath registers need no reset.
REQ-028 SHALL, on rst mid-transfer, abandon the transfer without emitting further descriptors or done.

Structure
REQ-029 SHALL place opcode constants (0x06,0x07,0x08,0x0A) and state encodings in the shared RoCE package.
REQ-030 SHALL be a single module; no sub-module.

Verification
REQ-031 PMTU_LOG2=12, length=10000, psn=0x000010, addr=0x1000 -> FIRST/4096/0x10/0x1000, MIDDLE/4096/0x11/0x2000, LAST/1808/0x12/0x3000; next_psn=0x13; one done pulse.
REQ-032 length=4096 -> single ONLY packet, len 4096, reth=1; length=0 -> single ONLY, len 0.
REQ-033 psn=0xFFFFFF, length=8192 -> FIRST psn 0xFFFFFF, LAST psn 0x000000; next_psn=0x000001.
REQ-034 m_pkt_ready toggled randomly during 5-packet transfer -> descriptors stable when stalled, no loss/duplication, s_wr_ready=0 throughout.
REQ-035 rst asserted after second of 3 packets -> m_pkt_valid=0 next cycle, no done, new request accepted normally afterward.

Source files
------------

// File: rtl/roce_tx_work_scheduler_pkg.sv
// Shared RoCE definitions for the TX work scheduler.
// This package holds the BTH opcodes and the scheduler state encoding.
package roce_tx_work_scheduler_pkg;

    localparam logic [7:0] OP_WRITE_FIRST  = 8'h06;
    localparam logic [7:0] OP_WRITE_MIDDLE = 8'h07;
    localparam logic [7:0] OP_WRITE_LAST   = 8'h08;
    localparam logic [7:0] OP_WRITE_ONLY   = 8'h0A;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_e;

endpackage

// File: rtl/roce_tx_work_scheduler.sv
// Splits one RDMA WRITE work request into PMTU-sized packet descriptors.
// It issues the descriptors back to back and tracks the next PSN.
//
// state    | meaning
// ST_IDLE  | waiting for a work request, s_wr_ready high
// ST_ISSUE | emitting descriptors until the final one is handshaken
module roce_tx_work_scheduler
    import roce_tx_work_scheduler_pkg::*;
#(
    parameter int PMTU_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_wr_valid,
    output logic        s_wr_ready,
    input  logic [31:0] s_wr_length,
    input  logic [63:0] s_wr_rem_addr,
    input  logic [31:0] s_wr_r_key,
    input  logic [23:0] s_wr_rem_qpn,
    input  logic [23:0] s_wr_psn,
    output logic        m_pkt_valid,
    input  logic        m_pkt_ready,
    output logic [7:0]  m_pkt_opcode,
    output logic [23:0] m_pkt_psn,
    output logic [63:0] m_pkt_addr,
    output logic [12:0] m_pkt_len,
    output logic        m_pkt_reth,
    output logic [31:0] m_pkt_r_key,
    output logic [23:0] m_pkt_qpn,
    output logic [31:0] m_pkt_dma_len,
    output logic [23:0] next_psn,
    output logic        done,
    output logic        busy
);

    localparam logic [31:0] PMTU_BYTES = 32'd1 << PMTU_LOG2;

    sched_state_e state, state_nxt;

    logic [31:0] rem_len;
    logic [31:0] dma_len;
    logic [63:0] addr;
    logic [31:0] r_key;
    logic [23:0] qpn;
    logic [23:0] psn;
    logic        first_pkt;
    logic        last_pkt;
    logic        accept;
    logic        pkt_fire;

    // Remaining bytes at or below one PMTU means this is the final packet;
    // comparing rather than pre-computing a packet count keeps it 32-bit.
    assign last_pkt = (rem_len <= PMTU_BYTES);
    assign accept   = s_wr_valid && s_wr_ready;
    assign pkt_fire = m_pkt_valid && m_pkt_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)               state_nxt = ST_ISSUE;
            ST_ISSUE: if (pkt_fire && last_pkt) state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_wr_ready    = (state == ST_IDLE) && !rst;
        m_pkt_valid   = (state == ST_ISSUE);
        busy          = (state == ST_ISSUE);
        m_pkt_reth    = first_pkt;
        m_pkt_psn     = psn;
        m_pkt_addr    = addr;
        m_pkt_r_key   = r_key;
        m_pkt_qpn     = qpn;
        m_pkt_dma_len = dma_len;
        m_pkt_len     = last_pkt ? rem_len[12:0] : PMTU_BYTES[12:0];
        if (first_pkt && last_pkt) m_pkt_opcode = OP_WRITE_ONLY;
        else if (first_pkt)        m_pkt_opcode = OP_WRITE_FIRST;
        else if (last_pkt)         m_pkt_opcode = OP_WRITE_LAST;
        else                       m_pkt_opcode = OP_WRITE_MIDDLE;
    end

    // Datapath holds only between handshakes, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_len   <= s_wr_length;
            dma_len   <= s_wr_length;
            addr      <= s_wr_rem_addr;
            r_key     <= s_wr_r_key;
            qpn       <= s_wr_rem_qpn;
            psn       <= s_wr_psn;
            first_pkt <= 1'b1;
        end else if (pkt_fire) begin
            rem_len   <= rem_len - PMTU_BYTES;
            addr      <= addr + 64'(PMTU_BYTES);
            psn       <= psn + 24'd1;
            first_pkt <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            next_psn <= 24'd0;
        end else begin
            done <= pkt_fire && last_pkt;
            if (pkt_fire && last_pkt) next_psn <= psn + 24'd1;
        end
    end

endmodule

// File: tb/tb_roce_tx_work_scheduler.sv
// Self-checking bench for roce_tx_work_scheduler: table of work requests,
// scoreboard of expected descriptors, plus a mid-transfer reset sequence.
module tb_roce_tx_work_scheduler;

    localparam int PMTU_LOG2 = 12;
    localparam longint unsigned PMTU = 64'd1 << PMTU_LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_wr_valid = 1'b0;
    logic        s_wr_ready;
    logic [31:0] s_wr_length = '0;
    logic [63:0] s_wr_rem_addr = '0;
    logic [31:0] s_wr_r_key = '0;
    logic [23:0] s_wr_rem_qpn = '0;
    logic [23:0] s_wr_psn = '0;
    logic        m_pkt_valid;
    logic        m_pkt_ready = 1'b1;
    logic [7:0]  m_pkt_opcode;
    logic [23:0] m_pkt_psn;
    logic [63:0] m_pkt_addr;
    logic [12:0] m_pkt_len;
    logic        m_pkt_reth;
    logic [31:0] m_pkt_r_key;
    logic [23:0] m_pkt_qpn;
    logic [31:0] m_pkt_dma_len;
    logic [23:0] next_psn;
    logic        done;
    logic        busy;

    roce_tx_work_scheduler #(.PMTU_LOG2(PMTU_LOG2)) dut (
        .clk(clk), .rst(rst),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
        .s_wr_length(s_wr_length), .s_wr_rem_addr(s_wr_rem_addr),
        .s_wr_r_key(s_wr_r_key), .s_wr_rem_qpn(s_wr_rem_qpn), .s_wr_psn(s_wr_psn),
        .m_pkt_valid(m_pkt_valid), .m_pkt_ready(m_pkt_ready),
        .m_pkt_opcode(m_pkt_opcode), .m_pkt_psn(m_pkt_psn), .m_pkt_addr(m_pkt_addr),
        .m_pkt_len(m_pkt_len), .m_pkt_reth(m_pkt_reth), .m_pkt_r_key(m_pkt_r_key),
        .m_pkt_qpn(m_pkt_qpn), .m_pkt_dma_len(m_pkt_dma_len),
        .next_psn(next_psn), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  opcode;
        logic [23:0] psn;
        logic [63:0] addr;
        logic [12:0] len;
        logic        reth;
        logic [31:0] r_key;
        logic [23:0] qpn;
        logic [31:0] dma_len;
    } pkt_t;

    typedef struct {
        logic [31:0] length;
        logic [23:0] psn;
        logic [63:0] addr;
        logic [31:0] r_key;
        logic [23:0] qpn;
        int          ready_mode;   // 0 always ready, 1 random
        bit          junk;         // hold s_wr_valid high with other fields while busy
        int          exp_count;
        logic [23:0] exp_next_psn;
    } vec_t;

    pkt_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pkt_seen = 0;
    int   ready_mode = 0;          // 2 = main process drives m_pkt_ready itself

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int push_expected(input vec_t v);
        longint unsigned cnt;
        pkt_t p;
        cnt = (v.length == 0) ? 1 : (longint'(v.length) + PMTU - 1) / PMTU;
        for (longint unsigned i = 0; i < cnt; i++) begin
            if (cnt == 1)          p.opcode = 8'h0A;
            else if (i == 0)       p.opcode = 8'h06;
            else if (i == cnt - 1) p.opcode = 8'h08;
            else                   p.opcode = 8'h07;
            p.len     = (i == cnt - 1) ? 13'(longint'(v.length) - (cnt - 1) * PMTU) : 13'(PMTU);
            p.psn     = 24'(longint'(v.psn) + i);
            p.addr    = v.addr + 64'(i * PMTU);
            p.reth    = (i == 0);
            p.r_key   = v.r_key;
            p.qpn     = v.qpn;
            p.dma_len = v.length;
            sb.push_back(p);
        end
        return int'(cnt);
    endfunction

    // Ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1)      m_pkt_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 0) m_pkt_ready = 1'b1;
        end
    end

    // Monitor: scoreboard pop on handshake, stability while stalled
    initial begin
        logic        stall_prev;
        logic [197:0] held;
        logic [197:0] cur;
        pkt_t e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {m_pkt_opcode, m_pkt_psn, m_pkt_addr, m_pkt_len, m_pkt_reth,
                   m_pkt_r_key, m_pkt_qpn, m_pkt_dma_len};
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (busy) check("wr_ready_while_busy", 256'(s_wr_ready), 256'(0));
                if (stall_prev) begin
                    check("stall_valid_held", 256'(m_pkt_valid), 256'(1));
                    check("stall_fields_held", 256'(cur), 256'(held));
                end
                if (m_pkt_valid && m_pkt_ready) begin
                    pkt_seen++;
                    if (sb.size() == 0) begin
                        check("unexpected_packet", 256'(m_pkt_psn), 256'(24'hDEAD));
                    end else begin
                        e = sb.pop_front();
                        check("pkt_opcode", 256'(m_pkt_opcode), 256'(e.opcode));
                        check("pkt_psn", 256'(m_pkt_psn), 256'(e.psn));
                        check("pkt_addr", 256'(m_pkt_addr), 256'(e.addr));
                        check("pkt_len", 256'(m_pkt_len), 256'(e.len));
                        check("pkt_reth", 256'(m_pkt_reth), 256'(e.reth));
                        check("pkt_qpn", 256'(m_pkt_qpn), 256'(e.qpn));
                        if (e.reth) begin
                            check("pkt_r_key", 256'(m_pkt_r_key), 256'(e.r_key));
                            check("pkt_dma_len", 256'(m_pkt_dma_len), 256'(e.dma_len));
                        end
                    end
                end
                stall_prev = m_pkt_valid && !m_pkt_ready;
                held = cur;
            end
        end
    end

    task automatic start_request(input vec_t v);
        int n;
        n = 0;
        while (!s_wr_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wr_ready_idle", 256'(s_wr_ready), 256'(1));
        s_wr_valid    = 1'b1;
        s_wr_length   = v.length;
        s_wr_rem_addr = v.addr;
        s_wr_r_key    = v.r_key;
        s_wr_rem_qpn  = v.qpn;
        s_wr_psn      = v.psn;
        @(posedge clk); #1;
        s_wr_valid = v.junk;
        if (v.junk) begin
            s_wr_length   = 32'd77;
            s_wr_rem_addr = 64'hBAD0;
            s_wr_psn      = 24'h00BEEF;
        end
        check("first_valid_after_accept", 256'(m_pkt_valid), 256'(1));
        check("busy_after_accept", 256'(busy), 256'(1));
    endtask

    task automatic run_transfer(input vec_t v);
        int cnt;
        int done_cnt;
        bit seen;
        ready_mode = v.ready_mode;
        pkt_seen = 0;
        cnt = push_expected(v);
        check("model_count", 256'(cnt), 256'(v.exp_count));
        start_request(v);
        done_cnt = 0;
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                done_cnt++;
                if (!seen) check("next_psn", 256'(next_psn), 256'(v.exp_next_psn));
                seen = 1;
            end else if (seen) begin
                break;
            end
            @(posedge clk); #1;
            s_wr_valid = v.junk && busy;
        end
        s_wr_valid = 1'b0;
        check("done_pulse_count", 256'(done_cnt), 256'(1));
        check("packet_count", 256'(pkt_seen), 256'(v.exp_count));
        check("scoreboard_empty", 256'(sb.size()), 256'(0));
        check("busy_after_done", 256'(busy), 256'(0));
        sb.delete();
    endtask

    vec_t vecs[7];

    initial begin
        vec_t rv;
        vecs[0] = '{32'd10000, 24'h000010, 64'h1000, 32'h1111_2222, 24'h0000AB, 0, 1'b0, 3, 24'h000013};
        vecs[1] = '{32'd4096,  24'h000005, 64'hABC0, 32'hCAFE_0001, 24'h123456, 0, 1'b0, 1, 24'h000006};
        vecs[2] = '{32'd0,     24'h123456, 64'h20,   32'h0BAD_F00D, 24'h000001, 1, 1'b0, 1, 24'h123457};
        vecs[3] = '{32'd8192,  24'hFFFFFF, 64'hFFFF_FFFF_FFFF_F000, 32'h5555_AAAA, 24'hFFFFFF, 0, 1'b0, 2, 24'h000001};
        vecs[4] = '{32'd20380, 24'h000100, 64'h8000, 32'h0000_0042, 24'h00C0DE, 1, 1'b1, 5, 24'h000105};
        vecs[5] = '{32'd4097,  24'h7FFFFE, 64'h0,    32'hFFFF_FFFF, 24'h000777, 1, 1'b0, 2, 24'h800000};
        vecs[6] = '{32'd8193,  24'hFFFFFE, 64'h40000, 32'h1234_5678, 24'h000999, 1, 1'b1, 3, 24'h000001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_ready", 256'(s_wr_ready), 256'(0));
        check("rst_pkt_valid", 256'(m_pkt_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_next_psn", 256'(next_psn), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_transfer(vecs[i]);

        // Reset after the second of three packets
        rv = '{32'd12288, 24'h000050, 64'h9000, 32'h0A0B_0C0D, 24'h000321, 2, 1'b0, 3, 24'h000053};
        ready_mode = 2;
        m_pkt_ready = 1'b1;
        pkt_seen = 0;
        void'(push_expected(rv));
        start_request(rv);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_seq_third_valid", 256'(m_pkt_valid), 256'(1));
        check("rst_seq_third_psn", 256'(m_pkt_psn), 256'(24'h000052));
        rst = 1'b1;
        m_pkt_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_seq_valid_cleared", 256'(m_pkt_valid), 256'(0));
        check("rst_seq_busy_cleared", 256'(busy), 256'(0));
        check("rst_seq_wr_ready_in_rst", 256'(s_wr_ready), 256'(0));
        check("rst_seq_pkts_before_rst", 256'(pkt_seen), 256'(2));
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rst_seq_no_done", 256'(done), 256'(0));
            check("rst_seq_no_valid", 256'(m_pkt_valid), 256'(0));
        end
        check("rst_seq_next_psn", 256'(next_psn), 256'(0));

        run_transfer(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
